clock_step_ctrl: RTL
====================

Name: clock_step_ctrl

Overview:
- Sequencing controller for the digital-clock counter chain: seconds (mod 60), minutes (mod 60) and hours (dec24 counter).
- In RUN mode it cascades the 1 Hz tick and the counter carries into one-cycle step pulses.
- In SET modes it freezes timekeeping and turns the up/down buttons into step/decrement pulses for one selected field, with auto-repeat.
- Sits between the debounced button front end and the three counters. Drives their step and dec inputs and the display blink select.

Parameters:
- REPEAT_DELAY, 8, cycles a button is held before the first auto-repeat step (>=1)
- REPEAT_RATE, 4, cycles between subsequent auto-repeat steps (>=1)
- CNT_W, 16, width of the internal hold counter; must hold REPEAT_DELAY+REPEAT_RATE

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse, once per second
- btn_mode  in  1  debounced, synchronised level
- btn_up  in  1  debounced, synchronised level
- btn_down  in  1  debounced, synchronised level
- sec_carry  in  1  one-cycle pulse, seconds wrapped 59->0
- min_carry  in  1  one-cycle pulse, minutes wrapped 59->0
- sec_step  out  1  one-cycle step pulse to the seconds counter
- min_step  out  1  one-cycle step pulse to the minutes counter
- hr_step  out  1  one-cycle step pulse to the hours counter
- step_dec  out  1  direction for the current step: 1 = decrement, 0 = increment
- mode  out  2  current mode (mode_t)
- blink  out  3  one-hot field select {hr,min,sec}; 000 in RUN

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk.
- Reset values: all outputs 0, mode=MODE_RUN, repeaters idle, edge history cleared. Reset mid-hold cancels the repeat; a still-held button must be released and re-pressed before it steps again.
- Output registers: all outputs are registered. Every response appears 1 cycle after the input is sampled.
- Mode FSM, advanced on rising edge of btn_mode only: MODE_RUN -> MODE_SET_HR -> MODE_SET_MIN -> MODE_SET_SEC -> MODE_RUN. A held btn_mode advances exactly once. A mode edge clears both repeaters in the same cycle.
- MODE_RUN:
  - sec_step = tick_1hz, min_step = sec_carry, hr_step = min_carry, each delayed 1 cycle.
  - step_dec = 0.
  - btn_up and btn_down are ignored, and their repeaters are held cleared.
- SET modes:
  - tick_1hz, sec_carry and min_carry are dropped (time frozen, no cascade).
  - Only the selected field's step output may pulse.
  - blink = 100 / 010 / 001 for HR / MIN / SEC.
- Auto-repeat, per button (btn_up, btn_down):
  - A rising edge sampled at cycle N starts the hold count at k=0.
  - Steps are requested at k = 0, REPEAT_DELAY, REPEAT_DELAY + REPEAT_RATE, REPEAT_DELAY + 2·REPEAT_RATE, and so on.
  - Each step pulse appears at cycle N+k+1.
  - Release returns the repeater to idle immediately; no further pulses.
- Direction: an up request gives step_dec=0; a down request gives step_dec=1. step_dec is valid in the same cycle as the step pulse and is 0 otherwise.
- Up and down together: whenever both are sampled high, no step is issued and both repeaters are cleared to idle. The button still held after the other is released does not step until it is re-pressed.
- Mode change with a pending repeat: no step is issued for the old field after the mode edge.
- Transition SET_SEC -> RUN: timekeeping resumes with the first tick_1hz sampled in RUN. Ticks dropped during SET are not made up.
- Width rules: the hold counter saturates at REPEAT_DELAY+REPEAT_RATE-1 and then reloads to REPEAT_DELAY, so it never wraps during an arbitrarily long hold.

Decomposition:
- Package clock_ctrl_pkg:
  - typedef enum logic [1:0] mode_t {MODE_RUN, MODE_SET_HR, MODE_SET_MIN, MODE_SET_SEC}
  - blink one-hot constants
- Sub-module btn_repeat: edge detect plus hold counter with a synchronous clear input and a one-cycle req output. Instantiated twice, once for up and once for down. Mode FSM and output muxing stay in clock_step_ctrl.

Test Plan:
- Reset, then pulse tick_1hz at cycle 10 and sec_carry at cycle 20 in RUN -> sec_step at 11, min_step at 21, hr_step never, blink=000, step_dec=0.
- Press btn_mode once, hold it 50 cycles -> mode=MODE_SET_HR, blink=100, exactly one mode advance. Then tick_1hz and min_carry pulses -> no step outputs.
- In SET_MIN, raise btn_up at cycle 100 and hold through cycle 125 (REPEAT_DELAY=8, REPEAT_RATE=4) -> min_step pulses at 101, 109, 113, 117, 121, 125 with step_dec=0; release at 126 -> no pulse at 129.
- In SET_SEC, btn_down pulse for 1 cycle -> single sec_step with step_dec=1. Then hold btn_up and btn_down together for 20 cycles -> no steps. Release btn_down -> still no step until btn_up is re-pressed.
- Four btn_mode presses from RUN -> modes HR, MIN, SEC, RUN in order. Assert reset while btn_up is held in SET_HR -> all outputs 0, mode=MODE_RUN, no hr_step after reset deasserts.

Source files
------------

// File: rtl/clock_step_ctrl_pkg.sv
// Shared types and constants for the digital-clock step controller.
// Holds the mode encoding, the display blink one-hot codes and two small
// helpers for mode sequencing.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  // The blink field is ordered {hr, min, sec}.
  localparam logic [2:0] BLINK_NONE = 3'b000;
  localparam logic [2:0] BLINK_HR   = 3'b100;
  localparam logic [2:0] BLINK_MIN  = 3'b010;
  localparam logic [2:0] BLINK_SEC  = 3'b001;

  // Cyclic mode order: RUN -> HR -> MIN -> SEC -> RUN.
  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      MODE_RUN:     next_mode = MODE_SET_HR;
      MODE_SET_HR:  next_mode = MODE_SET_MIN;
      MODE_SET_MIN: next_mode = MODE_SET_SEC;
      default:      next_mode = MODE_RUN;
    endcase
  endfunction

  // The field that blinks while that mode is active.
  function automatic logic [2:0] blink_of(input mode_t cur);
    case (cur)
      MODE_SET_HR:  blink_of = BLINK_HR;
      MODE_SET_MIN: blink_of = BLINK_MIN;
      MODE_SET_SEC: blink_of = BLINK_SEC;
      default:      blink_of = BLINK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_step_ctrl_btn_repeat.sv
// Single-button auto-repeater: rising-edge detect plus a hold counter.
// req is a combinational one-cycle request for the sample taken this cycle;
// the parent registers it. The counter saturates inside the repeat window
// and reloads, so arbitrarily long holds never wrap it.
module btn_repeat #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic req
);

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(REPEAT_DELAY + REPEAT_RATE - 1);

  logic             btn_prev;
  logic             active;
  logic [CNT_W-1:0] hold_cnt;
  logic             rise;

  // The edge history keeps tracking the button even while cleared, so a
  // button held across a clear needs a fresh press to step again.
  assign rise = btn & ~btn_prev;

  // Request on the initial press and each time the hold count hits the delay point.
  always_comb begin
    req = 1'b0;
    if (!clear) begin
      if (rise) begin
        req = 1'b1;
      end else if (active && btn && (hold_cnt == DELAY_C)) begin
        req = 1'b1;
      end
    end
  end

  // Edge history and hold counter; hold_cnt equals cycles since the press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev <= 1'b0;
      active   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      btn_prev <= btn;
      if (clear || !btn) begin
        active   <= 1'b0;
        hold_cnt <= '0;
      end else if (rise) begin
        active   <= 1'b1;
        hold_cnt <= CNT_W'(1);
      end else if (active) begin
        if (hold_cnt == LAST_C) begin
          hold_cnt <= DELAY_C;
        end else begin
          hold_cnt <= hold_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/clock_step_ctrl.sv
// Sequencing controller for the seconds/minutes/hours counter chain.
// RUN mode cascades the 1 Hz tick and counter carries into step pulses;
// SET modes freeze time and turn up/down buttons into auto-repeating
// step/decrement pulses for one selected field. All outputs registered.
module clock_step_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       sec_step,
  output logic       min_step,
  output logic       hr_step,
  output logic       step_dec,
  output mode_t      mode,
  output logic [2:0] blink
);

  logic  btn_mode_prev;
  logic  mode_edge;
  logic  clear_rep;
  logic  up_req;
  logic  down_req;
  logic  any_req;
  mode_t mode_nxt;

  // A mode press, RUN mode, or both buttons together all flush the repeaters.
  assign mode_edge = btn_mode & ~btn_mode_prev;
  assign clear_rep = (mode == MODE_RUN) | mode_edge | (btn_up & btn_down);
  assign mode_nxt  = mode_edge ? next_mode(mode) : mode;
  assign any_req   = up_req | down_req;

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) u_rep_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .clear(clear_rep),
    .req  (up_req)
  );

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE),
    .CNT_W       (CNT_W)
  ) u_rep_down (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .clear(clear_rep),
    .req  (down_req)
  );

  // Mode FSM with registered step, direction and blink outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_mode_prev <= 1'b0;
      mode          <= MODE_RUN;
      blink         <= BLINK_NONE;
      sec_step      <= 1'b0;
      min_step      <= 1'b0;
      hr_step       <= 1'b0;
      step_dec      <= 1'b0;
    end else begin
      btn_mode_prev <= btn_mode;
      mode          <= mode_nxt;
      blink         <= blink_of(mode_nxt);
      sec_step      <= 1'b0;
      min_step      <= 1'b0;
      hr_step       <= 1'b0;
      step_dec      <= 1'b0;
      case (mode)
        MODE_RUN: begin
          sec_step <= tick_1hz;
          min_step <= sec_carry;
          hr_step  <= min_carry;
        end
        MODE_SET_HR: begin
          hr_step  <= any_req;
          step_dec <= down_req;
        end
        MODE_SET_MIN: begin
          min_step <= any_req;
          step_dec <= down_req;
        end
        MODE_SET_SEC: begin
          sec_step <= any_req;
          step_dec <= down_req;
        end
        default: begin
          sec_step <= 1'b0;
        end
      endcase
    end
  end

endmodule
